fetch_stage: RTL

Instruction-fetch stage directly upstream of the instruction ROM and downstream-feeding the decode stage. Owns the program counter, drives the ROM address, captures the returned word into the IF/ID pipeline register, and applies stall, redirect (branch/jump/flush) and fetch-window fault handling. The ROM read is combinational, so the instruction for the current PC is sampled on the same clock edge that advances the PC.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 47 ++++
 rtl/fetch_addr_check.sv | 19 +
 rtl/fetch_stage.sv | 115 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ROM address/data, pipeline control and IF/ID outputs.
interface fetch_stage_if;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rd_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc_plus4_o;
  logic        if_id_valid_o;
  logic        fault_o;
  logic [31:0] fault_pc_o;
  logic [31:0] fetch_count_o;

  // Fetch stage side
  modport master (
    output instr_addr_o,
    input  instr_rd_i,
    input  stall_i,
    input  redirect_i,
    input  redirect_target_i,
    output if_id_instr_o,
    output if_id_pc_o,
    output if_id_pc_plus4_o,
    output if_id_valid_o,
    output fault_o,
    output fault_pc_o,
    output fetch_count_o
  );

  // ROM / pipeline-control / decode side
  modport slave (
    input  instr_addr_o,
    output instr_rd_i,
    output stall_i,
    output redirect_i,
    output redirect_target_i,
    input  if_id_instr_o,
    input  if_id_pc_o,
    input  if_id_pc_plus4_o,
    input  if_id_valid_o,
    input  fault_o,
    input  fault_pc_o,
    input  fetch_count_o
  );
endinterface

// File: rtl/fetch_addr_check.sv
// Combinational fetch-window legality check: word aligned and inside
// [base, base+size-4]. 33-bit compare so a wrapped address never passes.
module fetch_addr_check (
  input  logic [32:0] i_addr,
  input  logic [31:0] i_base,
  input  logic [31:0] i_size,
  output logic        o_legal
);
  logic [32:0] w_lo;
  logic [32:0] w_hi;

  assign w_lo = {1'b0, i_base};
  assign w_hi = {1'b0, i_base} + {1'b0, i_size} - 33'd4;

  // Aligned and within the inclusive window bounds
  always_comb begin
    o_legal = (i_addr[1:0] == 2'b00) && (i_addr >= w_lo) && (i_addr <= w_hi);
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational ROM,
// captures IF/ID, handles stall, redirect and fetch-window faults.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_VECTOR,
  parameter int unsigned ROM_BYTES = 4096,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);
  localparam logic [31:0] ROM_SIZE = 32'(ROM_BYTES);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  if_id_t       r_if_id, w_if_id_nxt;
  logic         r_fault, w_fault_nxt;
  logic [31:0]  r_fault_pc, w_fault_pc_nxt;
  logic [31:0]  r_count, w_count_nxt;

  logic [32:0]  w_pc_plus4;
  logic         w_pc4_legal;
  logic         w_tgt_legal;

  assign w_pc_plus4 = {1'b0, r_pc} + 33'd4;

  fetch_addr_check u_chk_target (
    .i_addr  ({1'b0, bus.redirect_target_i}),
    .i_base  (RESET_PC),
    .i_size  (ROM_SIZE),
    .o_legal (w_tgt_legal)
  );

  fetch_addr_check u_chk_pc4 (
    .i_addr  (w_pc_plus4),
    .i_base  (RESET_PC),
    .i_size  (ROM_SIZE),
    .o_legal (w_pc4_legal)
  );

  // State register: all architectural state, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_if_id    <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_id    <= w_if_id_nxt;
      r_fault    <= w_fault_nxt;
      r_fault_pc <= w_fault_pc_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // Next-state: redirect > stall > advance in RUN; HALT only drains to bubbles
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_id_nxt    = r_if_id;
    w_fault_nxt    = r_fault;
    w_fault_pc_nxt = r_fault_pc;
    w_count_nxt    = r_count;
    unique case (r_state)
      RUN: begin
        if (bus.redirect_i) begin
          // Bubble keeps the previous pc fields
          w_if_id_nxt.instr = NOP_INSTR;
          w_if_id_nxt.valid = 1'b0;
          if (w_tgt_legal) begin
            w_pc_nxt = bus.redirect_target_i;
          end else begin
            w_fault_nxt    = 1'b1;
            w_fault_pc_nxt = bus.redirect_target_i;
            w_state_nxt    = HALT;
          end
        end else if (!bus.stall_i) begin
          // Last in-window word is still delivered before halting
          w_if_id_nxt = '{instr: bus.instr_rd_i, pc: r_pc,
                          pc_plus4: w_pc_plus4[31:0], valid: 1'b1};
          w_count_nxt = r_count + 32'd1;
          if (w_pc4_legal) begin
            w_pc_nxt = w_pc_plus4[31:0];
          end else begin
            w_fault_nxt    = 1'b1;
            w_fault_pc_nxt = w_pc_plus4[31:0];
            w_state_nxt    = HALT;
          end
        end
      end
      HALT: begin
        if (!bus.stall_i) begin
          w_if_id_nxt.instr = NOP_INSTR;
          w_if_id_nxt.valid = 1'b0;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign bus.instr_addr_o     = r_pc;
  assign bus.if_id_instr_o    = r_if_id.instr;
  assign bus.if_id_pc_o       = r_if_id.pc;
  assign bus.if_id_pc_plus4_o = r_if_id.pc_plus4;
  assign bus.if_id_valid_o    = r_if_id.valid;
  assign bus.fault_o          = r_fault;
  assign bus.fault_pc_o       = r_fault_pc;
  assign bus.fetch_count_o    = r_count;
endmodule
